// File: rtl/enc_scheduler.sv
// Beat scheduler for an RS encoder: walks codeword positions ENC_SYM_NUM at a time,
// carrying over into the next codeword without a gap and pulling message symbols upstream.
module enc_scheduler #(
    parameter int ENC_SYM_NUM = 8,
    parameter int RS_MES_LEN  = 239,
    parameter int RS_COD_LEN  = 255
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               out_ready,
    output logic                               beat_valid,
    output logic [$clog2(RS_COD_LEN)-1:0]      con_counter,
    output logic [$clog2(ENC_SYM_NUM+1)-1:0]   mes_count,
    output logic                               cw_start,
    output logic                               cw_end,
    output logic [15:0]                        cw_count
);

    localparam int CW = $clog2(RS_COD_LEN);
    localparam int MW = $clog2(ENC_SYM_NUM + 1);
    // Two spare bits so c + ENC_SYM_NUM never overflows before the modulo step.
    localparam int XW = CW + 2;
    localparam logic [XW-1:0] SYM_X = XW'(ENC_SYM_NUM);
    localparam logic [XW-1:0] MES_X = XW'(RS_MES_LEN);
    localparam logic [XW-1:0] COD_X = XW'(RS_COD_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_MES, ST_PAR} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   con_counter_q, con_counter_d;
    logic [15:0]     cw_count_q, cw_count_d;

    logic [XW-1:0]   c_x, end_x, wrap_x, head_x, tail_x, next_x;
    logic            active, fire;

    always_comb begin
        c_x    = XW'(con_counter_q);
        end_x  = c_x + SYM_X;
        wrap_x = end_x - COD_X;
        head_x = '0;
        tail_x = '0;
        if (c_x < MES_X) begin
            head_x = ((MES_X - c_x) > SYM_X) ? SYM_X : (MES_X - c_x);
        end
        // Symbols spilling past the codeword end belong to the next codeword's message.
        if (end_x > COD_X) begin
            tail_x = (wrap_x < MES_X) ? wrap_x : MES_X;
        end
        mes_count = MW'(head_x + tail_x);
        next_x    = (end_x >= COD_X) ? wrap_x : end_x;
    end

    always_comb begin
        active        = (state_q != ST_IDLE);
        beat_valid    = active && ((mes_count == '0) || in_valid);
        in_ready      = active && out_ready && (mes_count != '0);
        cw_start      = active && ((c_x == '0) || (end_x > COD_X));
        cw_end        = active && (end_x >= COD_X);
        fire          = beat_valid && out_ready;
        state_d       = state_q;
        con_counter_d = con_counter_q;
        cw_count_d    = cw_count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_MES;
                end
            end
            default: begin
                if (fire) begin
                    con_counter_d = CW'(next_x);
                    state_d       = (next_x < MES_X) ? ST_MES : ST_PAR;
                    if (cw_end) begin
                        cw_count_d = cw_count_q + 16'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            con_counter_q <= '0;
            cw_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            con_counter_q <= con_counter_d;
            cw_count_q    <= cw_count_d;
        end
    end

    assign con_counter = con_counter_q;
    assign cw_count    = cw_count_q;

endmodule

// File: tb/tb_enc_scheduler.sv
// Bench for enc_scheduler: position-level reference model plus directed literal pins.
module tb_enc_scheduler;

    localparam int E   = 8;
    localparam int MES = 239;
    localparam int COD = 255;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic        in_ready, beat_valid, cw_start, cw_end;
    logic [7:0]  con_counter;
    logic [3:0]  mes_count;
    logic [15:0] cw_count;

    enc_scheduler #(.ENC_SYM_NUM(E), .RS_MES_LEN(MES), .RS_COD_LEN(COD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready), .beat_valid(beat_valid), .con_counter(con_counter),
        .mes_count(mes_count), .cw_start(cw_start), .cw_end(cw_end), .cw_count(cw_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          m_idle   = 1'b1;
    int          m_c      = 0;
    logic [15:0] m_cw     = '0;
    int          cw_total = 0;
    int          fires    = 0;
    int          consumed = 0;
    bit          last_end_fire;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference beat contents: enumerate the positions the beat covers.
    task automatic model_beat(output int mm, output bit ms, output bit me);
        int p;
        mm = 0; ms = 1'b0; me = 1'b0;
        for (int k = 0; k < E; k++) begin
            p = (m_c + k) % COD;
            if (p < MES) mm++;
            if (p == 0) ms = 1'b1;
            if (p == COD - 1) me = 1'b1;
        end
    endtask

    // Called just after a falling edge with inputs already applied for the next rising edge.
    task automatic cycle();
        int mm;
        bit ms, me, bv;
        #1;
        model_beat(mm, ms, me);
        bv = (mm == 0) || in_valid;
        if (m_idle) begin
            chk("idle_beat_valid", 32'(beat_valid), 0);
            chk("idle_in_ready", 32'(in_ready), 0);
            chk("idle_cw_start", 32'(cw_start), 0);
            chk("idle_cw_end", 32'(cw_end), 0);
        end else begin
            chk("beat_valid", 32'(beat_valid), 32'(bv));
            chk("in_ready", 32'(in_ready), 32'(out_ready && mm != 0));
            chk("mes_count", 32'(mes_count), 32'(mm));
            chk("cw_start", 32'(cw_start), 32'(ms));
            chk("cw_end", 32'(cw_end), 32'(me));
        end
        chk("con_counter", 32'(con_counter), 32'(m_c));
        chk("cw_count", 32'(cw_count), 32'(m_cw));
        if (in_valid && in_ready) consumed += 32'(mes_count);
        last_end_fire = 1'b0;
        if (!rst_n) begin
            m_idle = 1'b1; m_c = 0; m_cw = '0;
        end else if (m_idle) begin
            if (in_valid) m_idle = 1'b0;
        end else if (bv && out_ready) begin
            if (me) begin
                m_cw++;
                cw_total++;
                last_end_fire = 1'b1;
            end
            m_c = (m_c + E) % COD;
            fires++;
        end
        @(negedge clk);
    endtask

    initial begin
        int budget;
        int ends;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        repeat (2) cycle();
        chk("reset_con_counter", 32'(con_counter), 0);
        chk("reset_cw_count", 32'(cw_count), 0);
        chk("reset_beat_valid", 32'(beat_valid), 0);

        // Two codewords at full throughput, input withheld in the parity-only beats.
        fires = 0; consumed = 0; cw_total = 0; budget = 0;
        while (fires < 64 && budget < 200) begin
            rst_n = 1'b1; out_ready = 1'b1;
            in_valid = !(m_c == 240 || m_c == 241);
            #1;
            if (!m_idle) begin
                case (fires)
                    0:  begin chk("f0_c", 32'(con_counter), 0); chk("f0_start", 32'(cw_start), 1);
                              chk("f0_mes", 32'(mes_count), 8); chk("f0_budget", 32'(budget), 1); end
                    29: begin chk("f29_c", 32'(con_counter), 232); chk("f29_mes", 32'(mes_count), 7); end
                    30: begin chk("f30_c", 32'(con_counter), 240); chk("f30_mes", 32'(mes_count), 0);
                              chk("f30_in_ready", 32'(in_ready), 0); chk("f30_beat_valid", 32'(beat_valid), 1); end
                    31: begin chk("f31_c", 32'(con_counter), 248); chk("f31_mes", 32'(mes_count), 1);
                              chk("f31_start", 32'(cw_start), 1); chk("f31_end", 32'(cw_end), 1); end
                    32: begin chk("f32_c", 32'(con_counter), 1); chk("f32_cw", 32'(cw_count), 1); end
                    61: begin chk("f61_c", 32'(con_counter), 233); chk("f61_mes", 32'(mes_count), 6); end
                    63: begin chk("f63_c", 32'(con_counter), 249); chk("f63_mes", 32'(mes_count), 2); end
                    default: ;
                endcase
            end
            cycle();
            budget++;
        end
        chk("dir_done", 32'(fires), 64);
        #1;
        chk("dir_cw_count", 32'(cw_count), 2);
        chk("dir_con_counter", 32'(con_counter), 2);
        chk("dir_consumed", 32'(consumed), 480);

        // Random backpressure and input gaps.
        for (int i = 0; i < 3000; i++) begin
            rst_n = 1'b1;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 7) != 0);
            cycle();
        end
        chk("rand_consumed", 32'(consumed), 32'(MES * cw_total + ((m_c < MES) ? m_c : MES)));

        // Steer to c=120, stall, then reset while stalled.
        budget = 0;
        while (!(m_c == 120 && !m_idle) && budget < 400) begin
            rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
            cycle();
            budget++;
        end
        chk("reach_c120", 32'(m_c), 120);
        rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        cycle();
        rst_n = 1'b0; out_ready = 1'b0;
        cycle();
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_mid_c", 32'(con_counter), 0);
        chk("rst_mid_cw", 32'(cw_count), 0);
        chk("rst_mid_beat_valid", 32'(beat_valid), 0);
        chk("rst_mid_in_ready", 32'(in_ready), 0);

        // Codeword counter wrap from a preloaded value.
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        force dut.cw_count_q = 16'hFFFE;
        #1;
        release dut.cw_count_q;
        m_cw = 16'hFFFE;
        ends = 0; budget = 0;
        while (ends < 2 && budget < 200) begin
            rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
            cycle();
            budget++;
            if (last_end_fire) begin
                ends++;
                #1;
                chk("wrap_cw_count", 32'(cw_count), (ends == 1) ? 32'h0000FFFF : 32'h0);
            end
        end
        chk("wrap_done", 32'(ends), 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enc_scheduler.md
ENC_SCHEDULER -- requirements
Module: enc_scheduler

Interface
REQ-001 SHALL take parameter ENC_SYM_NUM, default from encoder.vh (8), symbols per beat.
REQ-002 SHALL take parameter RS_MES_LEN, default from encoder.vh (239), message symbols per codeword.
REQ-003 SHALL take parameter RS_COD_LEN, default from encoder.vh (255), codeword symbols; RS_MES_LEN < RS_COD_LEN and ENC_SYM_NUM < RS_COD_LEN.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  upstream message beat available.
REQ-007 SHALL have port in_ready  output  1  upstream beat consumed this cycle when in_valid also high.
REQ-008 SHALL have port out_ready  input  1  downstream encoder/buffer can take a beat.
REQ-009 SHALL have port beat_valid  output  1  current beat is issuable.
REQ-010 SHALL have port con_counter  output  $clog2(RS_COD_LEN)  codeword position of the beat's first symbol, range 0..RS_COD_LEN-1.
REQ-011 SHALL have port mes_count  output  $clog2(ENC_SYM_NUM+1)  message symbols in current beat (current plus next codeword).
REQ-012 SHALL have ports cw_start, cw_end  output  1 each  beat contains codeword position 0 / position RS_COD_LEN-1.
REQ-013 SHALL have port cw_count  output  16  completed codewords, wrapping.

Function
REQ-014 SHALL implement FSM states IDLE, MES, PAR.
REQ-015 IDLE: beat_valid=0, in_ready=0; SHALL go to MES the cycle after in_valid sampled high.
REQ-016 Beat covers positions c..c+ENC_SYM_NUM-1 modulo RS_COD_LEN, c = con_counter; positions < RS_MES_LEN are message.
REQ-017 mes_count SHALL be combinational: head = min(ENC_SYM_NUM, max(0, RS_MES_LEN-c)); if c+ENC_SYM_NUM > RS_COD_LEN, tail = min(c+ENC_SYM_NUM-RS_COD_LEN, RS_MES_LEN), else tail = 0; mes_count = head+tail; intermediates SHALL be sized to avoid overflow.
REQ-018 In MES/PAR, beat_valid SHALL = (mes_count==0) || in_valid; in_ready SHALL = out_ready && mes_count!=0.
REQ-019 fire = beat_valid && out_ready; on fire con_counter SHALL advance to c+ENC_SYM_NUM if < RS_COD_LEN, else c+ENC_SYM_NUM-RS_COD_LEN (carry-over, no gap between codewords).
REQ-020 On fire, next state SHALL be MES if next con_counter < RS_MES_LEN, else PAR.
REQ-021 Without fire, con_counter, state and cw_count SHALL hold (stall by out_ready low or in_valid low with mes_count!=0).
REQ-022 cw_start SHALL = state!=IDLE && (c==0 || c+ENC_SYM_NUM > RS_COD_LEN); cw_end SHALL = state!=IDLE && c+ENC_SYM_NUM >= RS_COD_LEN.
REQ-023 cw_count SHALL increment by 1 on each fire with cw_end=1, wrapping 0xFFFF->0.
REQ-024 SHALL never consume input (in_ready=0) while mes_count==0, regardless of in_valid.
REQ-025 SHALL never return to IDLE except by reset.

Reset
REQ-026 rst_n low at a rising edge SHALL set state=IDLE, con_counter=0, cw_count=0, regardless of state or stall.
REQ-027 During and after reset until MES entered, beat_valid, in_ready, cw_start, cw_end SHALL be 0; mes_count is don't-care.
REQ-028 Reset mid-codeword SHALL discard partial codeword; next codeword SHALL start at con_counter=0.

Verification (defaults 8/239/255)
REQ-029 Reset, in_valid=1, out_ready=1 -> one IDLE cycle, then c=0 with cw_start=1, mes_count=8, c steps 0,8,...,232.
REQ-030 Boundary: c=232 -> mes_count=7; c=240 -> mes_count=0, in_ready=0, beat_valid=1 with in_valid=0; c=248 -> mes_count=1, cw_start=1, cw_end=1, cw_count increments, next c=1.
REQ-031 Second codeword: c=1,9,... -> mes_count=8 until c=233 (mes_count=6), c=249 wraps to c=2; cw_count=2 after 64 fires.
REQ-032 out_ready toggled randomly, in_valid dropped mid-MES -> c held, no in_ready while out_ready=0, total consumed message symbols = 239 per codeword.
REQ-033 rst_n low at c=120 with out_ready=0 -> next cycle state IDLE, c=0, cw_count=0, beat_valid=0.
REQ-034 cw_count preloaded near wrap via 65536 codewords (or forced) -> 0xFFFF->0 on cw_end fire.
